// File: rtl/centroid_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// centroid_ctrl : drives weight/X/Y accumulators for a dark-spot centroid
// Rev 1.0
// ---------------------------------------------------------------------------
module centroid_ctrl #(
  parameter int FACTOR_WIDTH = 10,
  parameter int IDATA_WIDTH  = 8,
  parameter int ODATA_WIDTH  = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    iENABLE,
  input  logic                    iVSYNC,
  input  logic                    iHREF,
  input  logic                    iPIX_EN,
  input  logic [IDATA_WIDTH-1:0]  iPIX,
  input  logic [IDATA_WIDTH-1:0]  iTHRESH,
  output logic                    oCLR,
  output logic                    oDATA_EN,
  output logic [FACTOR_WIDTH-1:0] oX_FACTOR,
  output logic [FACTOR_WIDTH-1:0] oY_FACTOR,
  output logic [IDATA_WIDTH-1:0]  oW,
  input  logic [ODATA_WIDTH-1:0]  iSUM_W,
  input  logic [ODATA_WIDTH-1:0]  iSUM_X,
  input  logic [ODATA_WIDTH-1:0]  iSUM_Y,
  output logic [ODATA_WIDTH-1:0]  oRES_W,
  output logic [ODATA_WIDTH-1:0]  oRES_X,
  output logic [ODATA_WIDTH-1:0]  oRES_Y,
  output logic                    oRES_VALID,
  input  logic                    iRES_READY,
  output logic                    oDROP
);

  localparam logic [FACTOR_WIDTH-1:0] FACTOR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACTIVE = 3'd2,
    FLUSH  = 3'd3,
    LATCH  = 3'd4
  } state_t;

  state_t                  state, next_state;
  logic                    pix_ok;
  logic                    href_d;
  logic                    href_fall;
  logic [IDATA_WIDTH-1:0]  thresh;
  logic [IDATA_WIDTH-1:0]  weight;
  logic [FACTOR_WIDTH-1:0] x_cnt;
  logic [FACTOR_WIDTH-1:0] y_cnt;

  assign pix_ok    = (state == ACTIVE) && iHREF && iPIX_EN && !iVSYNC;
  assign href_fall = href_d && !iHREF;
  assign weight    = (iPIX < thresh) ? (thresh - iPIX) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    oCLR       = 1'b0;
    case (state)
      IDLE:   if (iVSYNC && iENABLE) next_state = CLEAR;
      CLEAR: begin
        oCLR       = 1'b1;
        next_state = ACTIVE;
      end
      // A frame boundary takes priority over an abandon request.
      ACTIVE: begin
        if (iVSYNC)        next_state = FLUSH;
        else if (!iENABLE) next_state = IDLE;
      end
      FLUSH:  next_state = LATCH;
      LATCH:  next_state = iENABLE ? CLEAR : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      thresh <= '0;
      href_d <= 1'b0;
    end else begin
      href_d <= iHREF;
      if (state == CLEAR) begin
        x_cnt  <= '0;
        y_cnt  <= '0;
        thresh <= iTHRESH;
      end else if (state == ACTIVE) begin
        if (pix_ok && (x_cnt != FACTOR_MAX)) x_cnt <= x_cnt + 1'b1;
        if (href_fall) begin
          x_cnt <= '0;
          if (y_cnt != FACTOR_MAX) y_cnt <= y_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      oDATA_EN  <= 1'b0;
      oW        <= '0;
      oX_FACTOR <= '0;
      oY_FACTOR <= '0;
    end else begin
      oDATA_EN <= pix_ok;
      if (pix_ok) begin
        oW        <= weight;
        oX_FACTOR <= x_cnt;
        oY_FACTOR <= y_cnt;
      end
    end
  end

  // An unconsumed result is never overwritten; the newer frame is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      oRES_W     <= '0;
      oRES_X     <= '0;
      oRES_Y     <= '0;
      oRES_VALID <= 1'b0;
      oDROP      <= 1'b0;
    end else begin
      oDROP <= 1'b0;
      if (state == LATCH) begin
        if (oRES_VALID && !iRES_READY) begin
          oDROP <= 1'b1;
        end else begin
          oRES_W     <= iSUM_W;
          oRES_X     <= iSUM_X;
          oRES_Y     <= iSUM_Y;
          oRES_VALID <= 1'b1;
        end
      end else if (oRES_VALID && iRES_READY) begin
        oRES_VALID <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/centroid_ctrl.md
CENTROID_CTRL -- requirements
Module: centroid_ctrl

Interface
REQ-001 Parameters SHALL be: FACTOR_WIDTH, default 10, coordinate counter width; IDATA_WIDTH, default 8, pixel and weight width; ODATA_WIDTH, default 16, accumulator-sum width.
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 iENABLE  input  1  level; frames are processed only while high.
REQ-005 iVSYNC  input  1  single-cycle frame-boundary pulse.
REQ-006 iHREF  input  1  line-valid level.
REQ-007 iPIX_EN  input  1  pixel strobe; qualified by iHREF.
REQ-008 iPIX  input  IDATA_WIDTH  pixel value.
REQ-009 iTHRESH  input  IDATA_WIDTH  darkness threshold, sampled at CLEAR.
REQ-010 oCLR  output  1  clear to all three accumulators.
REQ-011 oDATA_EN  output  1  accumulate enable to all three accumulators.
REQ-012 oX_FACTOR, oY_FACTOR  output  FACTOR_WIDTH each  column/row factor for X and Y accumulators.
REQ-013 oW  output  IDATA_WIDTH  pixel weight to all accumulators (weight-sum accumulator factor tied to 1 externally).
REQ-014 iSUM_W, iSUM_X, iSUM_Y  input  ODATA_WIDTH each  accumulator outputs.
REQ-015 oRES_W, oRES_X, oRES_Y  output  ODATA_WIDTH each  latched frame results.
REQ-016 oRES_VALID  output  1 / iRES_READY  input  1  result valid/ready handshake.
REQ-017 oDROP  output  1  one-cycle pulse when a finished frame is discarded.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, ACTIVE, FLUSH, LATCH.
REQ-019 IDLE: iVSYNC && iENABLE -> CLEAR; otherwise stay.
REQ-020 CLEAR: exactly one cycle with oCLR=1, x/y counters zeroed, iTHRESH captured -> ACTIVE.
REQ-021 ACTIVE: iVSYNC -> FLUSH; !iENABLE -> IDLE (frame abandoned, no result, no oDROP).
REQ-022 FLUSH: one cycle, oDATA_EN=0 -> LATCH; guarantees the last accumulate has landed.
REQ-023 LATCH: one cycle; captures iSUM_* into oRES_* -> CLEAR if iENABLE else IDLE.
REQ-024 Pixel accepted in ACTIVE iff iHREF && iPIX_EN && !iVSYNC; pixels in any other state or coincident with iVSYNC are ignored.
REQ-025 Weight = captured threshold - iPIX when iPIX < threshold, else 0 (unsigned, no underflow).
REQ-026 Accepted pixel at cycle n SHALL produce registered oDATA_EN=1, oW, oX_FACTOR=x, oY_FACTOR=y at cycle n+1; oDATA_EN=0 otherwise.
REQ-027 x increments after each accepted pixel, saturating at 2^FACTOR_WIDTH-1; x resets to 0 on iHREF falling edge.
REQ-028 y increments on each iHREF falling edge in ACTIVE, saturating at 2^FACTOR_WIDTH-1.
REQ-029 Accumulator overflow is not detected; sums wrap per ODATA_WIDTH.
REQ-030 In LATCH, if oRES_VALID=1 and iRES_READY=0, oRES_* SHALL be kept, new sums discarded, oDROP=1 for one cycle.
REQ-031 Otherwise in LATCH, oRES_* loaded and oRES_VALID=1 next cycle.
REQ-032 oRES_VALID clears on cycle after oRES_VALID && iRES_READY, unless a load occurs that same cycle (load wins, stays 1).
REQ-033 oRES_* SHALL be stable while oRES_VALID=1.

Reset
REQ-034 RST_N low SHALL immediately force state IDLE, x=y=0, threshold=0, oCLR=0, oDATA_EN=0, oX_FACTOR=oY_FACTOR=0, oW=0, oRES_*=0, oRES_VALID=0, oDROP=0.
REQ-035 Reset mid-frame discards partial frame; after release, a new iVSYNC is required before accumulation.

Verification
REQ-036 Reset, iENABLE=1, iVSYNC, thresh=100, one 3x2 frame all iPIX=40, iVSYNC -> oRES_W=360, oRES_X=360, oRES_Y=180, oRES_VALID=1.
REQ-037 Single dark pixel iPIX=0 at x=5,y=3, rest 255, thresh=50 -> oRES_W=50, oRES_X=250, oRES_Y=150.
REQ-038 iRES_READY=0 held across two complete frames -> first frame results retained, oDROP pulses once at second LATCH.
REQ-039 iPIX_EN high coincident with iVSYNC, and with iHREF=0 -> no oDATA_EN; sums unchanged.
REQ-040 RST_N low during ACTIVE then release, pixels without iVSYNC -> oCLR/oDATA_EN stay 0, oRES_VALID=0.
REQ-041 FACTOR_WIDTH=3, line of 10 accepted pixels -> oX_FACTOR saturates at 7 for pixels 8-10.
